i2s_rx: RTL

Serial-audio receiver for the ADC side of the codec link. Runs in the MCLK domain and uses the SCLK/LRCLK edge-anticipation strobes from the clock divider (`next_sclk_rise`, `next_lrclk_rise`, `next_lrclk_fall`) to sample `SDATA` on SCLK rising edges. It deserialises standard I2S frames (LRCLK low = left, one-bit delay, MSB first) into parallel left/right words. Each completed stereo pair goes to downstream DSP over a valid/ready handshake.

---
 rtl/i2s_rx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/i2s_rx.sv
// i2s_rx - serial-audio receiver for the ADC side of the codec link.
//
// Samples SDATA in the MCLK domain using the clock divider's edge-anticipation
// strobes, deserialises I2S-style frames (LRCLK low = left, MSB first,
// DELAY_BITS SCLK rises skipped after each LRCLK edge) and presents each
// completed left/right pair over a valid/ready handshake.
//
// Ports:
//   MCLK            - sole clock, all state updates on posedge
//   reset           - asynchronous, active-high; clears all state
//   SDATA           - serial data from the ADC
//   next_sclk_rise  - SCLK rises at this posedge (sample edge)
//   next_lrclk_rise - LRCLK rises at this posedge (right slot starts)
//   next_lrclk_fall - LRCLK falls at this posedge (left slot starts)
//   left_data       - left sample of the held pair
//   right_data      - right sample of the held pair
//   out_valid       - a pair is held
//   out_ready       - consumer accepts the held pair
//   overrun         - sticky: a completed pair was dropped
//   frame_err       - sticky: a framing violation was seen
module i2s_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int DELAY_BITS = 1,
  parameter int SLOT_BITS  = 32
) (
  input  logic                  MCLK,
  input  logic                  reset,
  input  logic                  SDATA,
  input  logic                  next_sclk_rise,
  input  logic                  next_lrclk_rise,
  input  logic                  next_lrclk_fall,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CW = $clog2(SLOT_BITS + 1);
  localparam logic [CW-1:0] SLOT_MAX  = CW'(SLOT_BITS);
  localparam logic [CW-1:0] SKIP_LAST = CW'((DELAY_BITS > 0) ? DELAY_BITS - 1 : 0);
  localparam logic [CW-1:0] CAP_LAST  = CW'(DELAY_BITS + DATA_WIDTH - 1);

  typedef enum logic [1:0] {SYNC, SKIP, SHIFT, PAD} state_t;

  // With no delay bits a slot starts capturing straight away.
  localparam state_t SLOT_ENTRY = (DELAY_BITS == 0) ? SHIFT : SKIP;

  state_t                state;
  logic                  chan_right;
  logic [CW-1:0]         cnt;
  // Only the DATA_WIDTH-1 previously captured bits are kept; the current
  // SDATA bit completes the word in shreg_next.
  logic [DATA_WIDTH-2:0] shreg;
  logic [DATA_WIDTH-1:0] left_hold;

  logic                  lr_edge;
  logic                  new_right;
  logic                  wrong_chan;
  logic                  emit;
  logic [DATA_WIDTH-1:0] shreg_next;

  always_comb begin
    lr_edge    = next_lrclk_fall | next_lrclk_rise;
    // A simultaneous rise/fall strobe pair is resolved as a fall.
    new_right  = ~next_lrclk_fall;
    // Slot type must alternate: a new slot of the current channel is illegal.
    wrong_chan = (new_right == chan_right);
    shreg_next = {shreg, SDATA};
    emit       = (state == SHIFT) && chan_right && next_sclk_rise && !lr_edge &&
                 (cnt == CAP_LAST) && (cnt != SLOT_MAX);
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      chan_right <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      left_hold  <= '0;
      left_data  <= '0;
      right_data <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // Output handshake: an emit on the same edge as a transfer wins.
      if (emit) begin
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end else begin
          left_data  <= left_hold;
          right_data <= shreg_next;
          out_valid  <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        SYNC: begin
          if (next_lrclk_fall) begin
            state      <= SLOT_ENTRY;
            chan_right <= 1'b0;
            cnt        <= '0;
          end
        end

        default: begin
          if (lr_edge) begin
            // LR edge takes priority over a coincident sample edge.
            cnt <= '0;
            if (state != PAD) begin
              frame_err <= 1'b1;
            end
            if (wrong_chan) begin
              frame_err <= 1'b1;
              state     <= SYNC;
            end else begin
              state      <= SLOT_ENTRY;
              chan_right <= new_right;
            end
          end else if (next_sclk_rise) begin
            if (cnt == SLOT_MAX) begin
              // Slot ran past its length: LRCLK went missing.
              frame_err <= 1'b1;
              state     <= SYNC;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
              case (state)
                SKIP: begin
                  if (cnt == SKIP_LAST) begin
                    state <= SHIFT;
                  end
                end
                SHIFT: begin
                  shreg <= shreg_next[DATA_WIDTH-2:0];
                  if (cnt == CAP_LAST) begin
                    if (!chan_right) begin
                      left_hold <= shreg_next;
                    end
                    state <= PAD;
                  end
                end
                default: begin
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
